// File: rtl/apb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_arbiter_pkg
//
// Purpose : Shared definitions for the APB bus arbiter: the FSM state
//           encoding, the fixed APB data width and a helper that sizes
//           master index fields.
//
// Contents:
//   state_e     - arbiter FSM states (IDLE/SETUP/ACCESS/RESP)
//   APB_DATA_W  - width of PWDATA/PRDATA and of every master data slice
//   idxWidth()  - bits needed to hold a master index (never less than 1)
// ---------------------------------------------------------------------------
package apb_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int APB_DATA_W = 8;

   // A single master still needs a one-bit index so that every index
   // signal has a legal, non-zero width.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//
// Purpose : Purely combinational winner selection for the APB arbiter.
//           With APB_ARBITER_ROUND_ROBIN_EN defined the search starts one
//           past the previously granted master and wraps around; otherwise
//           it is a lowest-set-bit encoder (fixed priority, master 0 first).
//
// Macro   : APB_ARBITER_ROUND_ROBIN_EN (defined = round robin,
//           undefined = fixed priority, last_i port removed)
//
// Ports:
//   req_i        in   MASTER_COUNT  request vector (one bit per master)
//   last_i       in   IDX_W         most recently granted index (RR only)
//   grant_o      out  MASTER_COUNT  one-hot winner, all zero if no request
//   grant_idx_o  out  IDX_W         binary index of the winner
// ---------------------------------------------------------------------------
module rr_priority_picker #(
   parameter int MASTER_COUNT = 2,
   parameter int IDX_W        = 1
) (
   input  logic [MASTER_COUNT-1:0] req_i,
`ifdef APB_ARBITER_ROUND_ROBIN_EN
   input  logic [IDX_W-1:0]        last_i,
`endif
   output logic [MASTER_COUNT-1:0] grant_o,
   output logic [IDX_W-1:0]        grant_idx_o
);

`ifdef APB_ARBITER_ROUND_ROBIN_EN

   // The candidate is one bit wider than an index so that last_i+offset can
   // reach 2*MASTER_COUNT-1 without overflowing before it is wrapped back.
   localparam int CW = IDX_W + 1;

   logic [CW-1:0] cand;
   logic          found;

   // Walk the masters in round-robin order starting at last_i+1 (offset 1)
   // and ending at last_i itself (offset MASTER_COUNT), so the previous
   // winner gets the lowest priority. The first asserted request wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int off = 1; off <= MASTER_COUNT; off++) begin
         cand = {1'b0, last_i} + CW'(off);
         if (cand >= CW'(MASTER_COUNT)) begin
            cand = cand - CW'(MASTER_COUNT);
         end
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found                       = 1'b1;
            grant_o[cand[IDX_W-1:0]]    = 1'b1;
            grant_idx_o                 = cand[IDX_W-1:0];
         end
      end
   end

`else

   // Fixed priority: scan from the top index down so that the lowest
   // asserted request is the last one written and therefore wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            grant_o     = '0;
            grant_o[i]  = 1'b1;
            grant_idx_o = IDX_W'(i);
         end
      end
   end

`endif

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//
// Purpose : Shares one APB2 slave bus between MASTER_COUNT APB3-style
//           masters. A winner is chosen in IDLE, its address, direction and
//           write data are latched, and the transfer is replayed on the slave
//           bus as a fixed SETUP/ACCESS pair. The slave read data captured at
//           the end of ACCESS is returned to the winner together with a
//           one-cycle m_pready strobe in RESP. One transfer every 4 cycles.
//
// Macro   : APB_ARBITER_ROUND_ROBIN_EN (defined = round robin arbitration,
//           undefined = fixed priority, lowest index wins)
//
// Parameters:
//   MASTER_COUNT  number of masters, 1..8
//   ADDR_BYTES    APB address width in bytes
//
// Ports:
//   clk        in   1                      system clock, rising edge
//   rst        in   1                      synchronous reset, active low
//   m_paddr    in   MASTER_COUNT*ADDR_W    per-master address, slice i
//   m_psel     in   MASTER_COUNT           per-master request
//   m_penable  in   MASTER_COUNT           per-master access phase (ignored)
//   m_pwrite   in   MASTER_COUNT           per-master direction, 1 = write
//   m_pwdata   in   MASTER_COUNT*8         per-master write data
//   m_prdata   out  MASTER_COUNT*8         per-master read data (in RESP)
//   m_pready   out  MASTER_COUNT           per-master completion strobe
//   PADDR      out  ADDR_W                 slave address
//   PSEL       out  1                      slave select
//   PENABLE    out  1                      slave access phase
//   PWRITE     out  1                      slave direction
//   PWDATA     out  8                      slave write data
//   PRDATA     in   8                      slave read data
// ---------------------------------------------------------------------------
module apb_arbiter
   import apb_arbiter_pkg::*;
#(
   parameter int MASTER_COUNT = 2,
   parameter int ADDR_BYTES   = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [MASTER_COUNT*ADDR_BYTES*8-1:0] m_paddr,
   input  logic [MASTER_COUNT-1:0]             m_psel,
   input  logic [MASTER_COUNT-1:0]             m_penable,
   input  logic [MASTER_COUNT-1:0]             m_pwrite,
   input  logic [MASTER_COUNT*8-1:0]           m_pwdata,
   output logic [MASTER_COUNT*8-1:0]           m_prdata,
   output logic [MASTER_COUNT-1:0]             m_pready,
   output logic [ADDR_BYTES*8-1:0]             PADDR,
   output logic                                PSEL,
   output logic                                PENABLE,
   output logic                                PWRITE,
   output logic [7:0]                          PWDATA,
   input  logic [7:0]                          PRDATA
);

   localparam int ADDR_W = ADDR_BYTES * 8;
   localparam int IDX_W  = idxWidth(MASTER_COUNT);

   state_e                   state_q, state_d;
   logic [MASTER_COUNT-1:0]  grant_q;
   logic [ADDR_W-1:0]        addr_q;
   logic                     write_q;
   logic [APB_DATA_W-1:0]    wdata_q;
   logic [APB_DATA_W-1:0]    rdata_q;
`ifdef APB_ARBITER_ROUND_ROBIN_EN
   logic [IDX_W-1:0]         last_q;
`endif

   logic [MASTER_COUNT-1:0]  pickGrant;
   logic [IDX_W-1:0]         pickIdx;
   logic                     arbitrate;
   logic [ADDR_W-1:0]        selAddr;
   logic                     selWrite;
   logic [APB_DATA_W-1:0]    selWdata;
   logic                     penable_unused;

   // Masters still drive an access phase, but the slave-side phases are
   // generated here from the FSM, so the master's own PENABLE carries no
   // information for the arbiter.
   assign penable_unused = ^m_penable;

   // With a single master there is nothing to arbitrate: the only master is
   // always the winner and no pointer is kept.
   generate
      if (MASTER_COUNT == 1) begin : g_single
         assign pickGrant = 1'b1;
         assign pickIdx   = '0;
      end else begin : g_multi
         rr_priority_picker #(
            .MASTER_COUNT (MASTER_COUNT),
            .IDX_W        (IDX_W)
         ) u_picker (
            .req_i        (m_psel),
`ifdef APB_ARBITER_ROUND_ROBIN_EN
            .last_i       (last_q),
`endif
            .grant_o      (pickGrant),
            .grant_idx_o  (pickIdx)
         );
      end
   endgenerate

   // Arbitration happens only in IDLE; requests seen in any other state
   // simply wait, because the masters hold them until their m_pready.
   assign arbitrate = (state_q == ST_IDLE) && (|m_psel);

   // Route the winner's transfer attributes to the latch inputs.
   assign selAddr  = m_paddr[int'(pickIdx)*ADDR_W +: ADDR_W];
   assign selWrite = m_pwrite[pickIdx];
   assign selWdata = m_pwdata[int'(pickIdx)*APB_DATA_W +: APB_DATA_W];

   // State register. Reset is synchronous and may cut a transfer short in
   // any state; the slave simply never sees the ACCESS phase completed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the only decision point is IDLE, every other state
   // advances unconditionally, which fixes the 4-cycle transfer length.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (|m_psel) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Transfer registers. The winner's request is captured once at grant so
   // the slave bus stays stable even if the master misbehaves afterwards.
   // Slave read data is captured at the end of every ACCESS cycle, writes
   // included, so the returned m_prdata is always the slave's last answer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_q <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef APB_ARBITER_ROUND_ROBIN_EN
         last_q  <= IDX_W'(MASTER_COUNT - 1);
`endif
      end else begin
         if (arbitrate) begin
            grant_q <= pickGrant;
            addr_q  <= selAddr;
            write_q <= selWrite;
            wdata_q <= selWdata;
`ifdef APB_ARBITER_ROUND_ROBIN_EN
            last_q  <= pickIdx;
`endif
         end
         if (state_q == ST_ACCESS) begin
            rdata_q <= PRDATA;
         end
      end
   end

   // Output decode. Slave controls follow the state directly; the master
   // side only ever shows the granted master's strobe and data in RESP so
   // that all other m_prdata slices read as zero.
   always_comb begin
      PSEL     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
      PENABLE  = (state_q == ST_ACCESS);
      PWRITE   = write_q && ((state_q == ST_SETUP) || (state_q == ST_ACCESS));
      PADDR    = addr_q;
      PWDATA   = wdata_q;
      m_pready = '0;
      m_prdata = '0;
      if (state_q == ST_RESP) begin
         m_pready = grant_q;
         for (int i = 0; i < MASTER_COUNT; i++) begin
            if (grant_q[i]) begin
               m_prdata[i*APB_DATA_W +: APB_DATA_W] = rdata_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//
// Purpose : Self-checking bench for apb_arbiter (MASTER_COUNT=2,
//           ADDR_BYTES=1). A transaction-level model predicts, for every
//           cycle, the slave bus phases and the master completion strobes
//           from the arbitration rules; directed steps cover the named
//           scenarios and a randomized phase follows.
//
// Macro   : APB_ARBITER_ROUND_ROBIN_EN selects which arbitration rule the
//           model applies, matching the DUT build.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

   localparam int MC = 2;
   localparam int AB = 1;
   localparam int AW = AB * 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [MC*AW-1:0]  m_paddr;
   logic [MC-1:0]     m_psel;
   logic [MC-1:0]     m_penable;
   logic [MC-1:0]     m_pwrite;
   logic [MC*8-1:0]   m_pwdata;
   logic [MC*8-1:0]   m_prdata;
   logic [MC-1:0]     m_pready;
   logic [AW-1:0]     PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [7:0]        PWDATA;
   logic [7:0]        PRDATA;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   apb_arbiter #(
      .MASTER_COUNT (MC),
      .ADDR_BYTES   (AB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_paddr   (m_paddr),
      .m_psel    (m_psel),
      .m_penable (m_penable),
      .m_pwrite  (m_pwrite),
      .m_pwdata  (m_pwdata),
      .m_prdata  (m_prdata),
      .m_pready  (m_pready),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Transaction-level model: one outstanding slave transfer at most.
   bit          txValid   = 1'b0;
   int          txStart   = 0;
   int          txWin     = 0;
   logic [AW-1:0] txAddr  = '0;
   logic        txWrite   = 1'b0;
   logic [7:0]  txWdata   = '0;
   logic [7:0]  txRdata   = '0;
   int          freeAt    = 0;
   int          lastIdx   = MC - 1;
   bit          justReset = 1'b0;
   int          forcedRdata = -1;

   int   grantLog[$];
   int   grantCyc[$];
   int   riseCyc[$];
   logic pselPrev = 1'b0;

   // Single comparison point: count it, and report any difference.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Master-side request helpers.
   task automatic startReq(input int i, input logic [AW-1:0] a, input logic w, input logic [7:0] d);
      m_psel[i]            = 1'b1;
      m_penable[i]         = 1'b0;
      m_paddr[i*AW +: AW]  = a;
      m_pwrite[i]          = w;
      m_pwdata[i*8 +: 8]   = d;
   endtask

   task automatic dropReq(input int i);
      m_psel[i]    = 1'b0;
      m_penable[i] = 1'b0;
   endtask

   // Compare the DUT against what the model says this cycle should look
   // like, then log completions and PSEL rising edges for directed checks.
   task automatic checkOutput();
      int             d;
      logic           expSel, expEn;
      logic [MC-1:0]  expReady;
      logic [MC*8-1:0] expRdata;
      d        = -1;
      expSel   = 1'b0;
      expEn    = 1'b0;
      expReady = '0;
      expRdata = '0;
      if (txValid) d = cyc - txStart;
      if (d == 1 || d == 2) expSel = 1'b1;
      if (d == 2) expEn = 1'b1;
      if (d == 3) begin
         expReady = MC'(1) << txWin;
         expRdata = (MC*8)'(txRdata) << (8 * txWin);
      end
      check("psel",    32'(PSEL),     32'(expSel));
      check("penable", 32'(PENABLE),  32'(expEn));
      check("pready",  32'(m_pready), 32'(expReady));
      check("prdata",  32'(m_prdata), 32'(expRdata));
      if (expSel) begin
         check("paddr",  32'(PADDR),  32'(txAddr));
         check("pwrite", 32'(PWRITE), 32'(txWrite));
         check("pwdata", 32'(PWDATA), 32'(txWdata));
      end
      if (justReset) begin
         check("rst_paddr",  32'(PADDR),  32'd0);
         check("rst_pwdata", 32'(PWDATA), 32'd0);
         check("rst_pwrite", 32'(PWRITE), 32'd0);
      end
      for (int i = 0; i < MC; i++) begin
         if (m_pready[i]) begin
            grantLog.push_back(i);
            grantCyc.push_back(cyc);
         end
      end
      if (PSEL && !pselPrev) riseCyc.push_back(cyc);
      pselPrev  = PSEL;
      justReset = 1'b0;
      if (txValid && d >= 3) txValid = 1'b0;
   endtask

   // End of the current cycle: let the model arbitrate on the inputs that
   // are now applied, drive slave read data, advance one clock and check.
   task automatic applyStimulus();
      bit rstSeen;
      int w;
      PRDATA = (forcedRdata >= 0) ? 8'(forcedRdata) : 8'($urandom);
      if (txValid && cyc == txStart + 2) txRdata = PRDATA;
      if (rst && cyc >= freeAt && m_psel != '0) begin
         w = -1;
`ifdef APB_ARBITER_ROUND_ROBIN_EN
         for (int off = 1; off <= MC; off++) begin
            int c;
            c = (lastIdx + off) % MC;
            if (w < 0 && m_psel[c]) w = c;
         end
`else
         for (int i = 0; i < MC; i++) begin
            if (w < 0 && m_psel[i]) w = i;
         end
`endif
         txValid = 1'b1;
         txStart = cyc;
         txWin   = w;
         txAddr  = m_paddr[w*AW +: AW];
         txWrite = m_pwrite[w];
         txWdata = m_pwdata[w*8 +: 8];
         freeAt  = cyc + 4;
         lastIdx = w;
      end
      rstSeen = !rst;
      @(posedge clk);
      #1;
      cyc++;
      if (rstSeen) begin
         txValid   = 1'b0;
         freeAt    = cyc;
         lastIdx   = MC - 1;
         justReset = 1'b1;
      end
      checkOutput();
   endtask

   // Run n cycles; a master whose m_pready is seen either leaves or
   // immediately issues a fresh random request.
   task automatic runCycles(input int n, input bit rereq);
      for (int j = 0; j < n; j++) begin
         for (int i = 0; i < MC; i++) begin
            if (m_pready[i]) begin
               if (rereq) startReq(i, AW'($urandom), 1'($urandom), 8'($urandom));
               else       dropReq(i);
            end
         end
         applyStimulus();
      end
   endtask

   task automatic clearLogs();
      grantLog.delete();
      grantCyc.delete();
      riseCyc.delete();
   endtask

   initial begin
      int expCont[3];
`ifdef APB_ARBITER_ROUND_ROBIN_EN
      expCont = '{0, 1, 0};
`else
      expCont = '{0, 0, 0};
`endif
      rst       = 1'b0;
      m_paddr   = '0;
      m_psel    = '0;
      m_penable = '0;
      m_pwrite  = '0;
      m_pwdata  = '0;
      PRDATA    = '0;

      $display("[TB] reset");
      applyStimulus();
      applyStimulus();
      rst = 1'b1;
      runCycles(2, 1'b0);

      $display("[TB] single write m0");
      clearLogs();
      startReq(0, AW'('h12), 1'b1, 8'hA5);
      runCycles(6, 1'b0);
      check("write_done", 32'(grantLog.size()), 32'd1);

      $display("[TB] single read m1");
      clearLogs();
      forcedRdata = 'h3C;
      startReq(1, AW'('h05), 1'b0, 8'h00);
      runCycles(6, 1'b0);
      forcedRdata = -1;
      check("read_done", 32'(grantLog.size()), 32'd1);
      check("read_who",  32'(grantLog[0]),     32'd1);

      $display("[TB] contention from reset");
      rst = 1'b0;
      applyStimulus();
      rst = 1'b1;
      clearLogs();
      startReq(0, AW'($urandom), 1'($urandom), 8'($urandom));
      startReq(1, AW'($urandom), 1'($urandom), 8'($urandom));
      runCycles(12, 1'b1);
      check("cont_count", 32'(grantLog.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("cont_grant%0d", k), 32'(grantLog[k]), 32'(expCont[k]));
      end
      check("cont_spacing", 32'(grantCyc[1] - grantCyc[0]), 32'd4);
      runCycles(12, 1'b0);

      $display("[TB] late request");
      clearLogs();
      startReq(0, AW'('h21), 1'b1, 8'h5A);
      applyStimulus();
      applyStimulus();
      startReq(1, AW'('h31), 1'b0, 8'h00);
      runCycles(10, 1'b0);
      check("late_count", 32'(grantLog.size()), 32'd2);
      check("late_second", 32'(grantLog[1]), 32'd1);
      check("late_gap", 32'(riseCyc[1] - grantCyc[0]), 32'd2);

      $display("[TB] reset mid-transfer");
      clearLogs();
      startReq(0, AW'('h44), 1'b1, 8'h11);
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      startReq(1, AW'('h55), 1'b1, 8'h22);
      applyStimulus();
      rst = 1'b1;
      check("rst_no_complete", 32'(grantLog.size()), 32'd0);
      clearLogs();
      runCycles(14, 1'b0);
      check("rst_count", 32'(grantLog.size()), 32'd2);
      check("rst_first", 32'(grantLog[0]),     32'd0);

      $display("[TB] dropped request");
      clearLogs();
      startReq(0, AW'('h66), 1'b0, 8'h00);
      applyStimulus();
      dropReq(0);
      runCycles(6, 1'b0);
      check("drop_count", 32'(grantLog.size()), 32'd1);
      check("drop_who",   32'(grantLog[0]),     32'd0);

      $display("[TB] random traffic");
      for (int j = 0; j < 400; j++) begin
         for (int i = 0; i < MC; i++) begin
            if (m_pready[i]) dropReq(i);
            if (!m_psel[i] && $urandom_range(0, 2) == 0) begin
               startReq(i, AW'($urandom), 1'($urandom), 8'($urandom));
            end
         end
         applyStimulus();
      end
      runCycles(20, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Shares the single APB2 register bus (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA) between several bus masters: the SPI-to-APB bridge and future requesters such as a second control port or a self-test sequencer. Each master uses an APB3-style port with PREADY back-pressure. The arbiter serialises their transfers onto the fixed two-cycle APB2 slave bus. Arbitration is round-robin by default, and the slave side is fully registered.

## Interface
- `MASTER_COUNT`, default 2: number of requesting masters; legal range 1..8.
- `ADDR_BYTES`, default 1: APB address width in bytes; must equal the slave bus width.

- `clk`, input, 1: single system clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `m_paddr`, input, `MASTER_COUNT*ADDR_BYTES*8`: per-master address; master i occupies slice i.
- `m_psel`, input, `MASTER_COUNT`: per-master select (request).
- `m_penable`, input, `MASTER_COUNT`: per-master access phase.
- `m_pwrite`, input, `MASTER_COUNT`: per-master direction; 1 = write.
- `m_pwdata`, input, `MASTER_COUNT*8`: per-master write data.
- `m_prdata`, output, `MASTER_COUNT*8`: per-master read data; valid only while that master's `m_pready` is 1.
- `m_pready`, output, `MASTER_COUNT`: one-cycle transfer-complete strobe per master.
- `PADDR`, output, `ADDR_BYTES*8`: slave address.
- `PSEL`, `PENABLE`, `PWRITE`, output, 1 each: slave APB2 control.
- `PWDATA`, output, 8: slave write data.
- `PRDATA`, input, 8: slave read data.

## Operation
- States: `IDLE`, `SETUP`, `ACCESS`, `RESP`.
- **IDLE**
  - Request vector is `m_psel`.
  - If any bit is set, pick a winner, register `grant` (one-hot), and latch the winner's addr, pwrite and pwdata. Go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**: `PSEL`=1, `PENABLE`=0, latched addr/write/wdata driven. Go to ACCESS.
- **ACCESS**
  - `PSEL`=1, `PENABLE`=1.
  - `PRDATA` is captured into `rdata` at the end of this cycle, on reads and writes alike.
  - Go to RESP.
- **RESP**
  - `m_pready[grant]`=1 and `m_prdata[grant]`=`rdata`; all other `m_pready` bits are 0. `PSEL`/`PENABLE` = 0.
  - Go to IDLE.
- **Round-robin**
  - Pointer `last` holds the most recently granted index.
  - The search starts at `last+1` and wraps modulo `MASTER_COUNT`; the first set request wins.
  - `last` updates only on grant.
- Masters must hold psel/addr/write/wdata stable until `m_pready`. `m_penable` is ignored; it is present for protocol completeness.
- A master that drops `m_psel` mid-transfer breaks the protocol. The slave transfer still completes and RESP still pulses; no abort.
- Non-granted `m_prdata` slices are driven to 0.
- With `MASTER_COUNT`=1, `grant` is constant 1 and the pointer logic is removed.

## Timing
- Reset (`rst`=0 at a clock edge), taking effect at that edge:
  - State goes to IDLE; `last` = `MASTER_COUNT-1`, so master 0 wins first.
  - `PSEL`, `PENABLE`, `PWRITE` = 0; `PADDR`, `PWDATA` = 0; all `m_pready` = 0; all `m_prdata` = 0.
  - Applies mid-transfer with no slave completion.
- Latency: with a request at cycle N in IDLE, `PSEL` rises at N+1, `PENABLE` at N+2, and `m_pready` pulses at N+3.
- The earliest next arbitration is cycle N+4, so back-to-back throughput is one transfer per 4 cycles.
- Requests arriving during SETUP/ACCESS/RESP wait; they are arbitrated at the next IDLE cycle.
- A master whose `m_pready` pulsed at cycle N+3 and still asserts `m_psel` at N+4 is treated as a new request.
- Simultaneous requests are resolved in a single cycle; no request is starved longer than `MASTER_COUNT-1` transfers.

## Configuration
- Macro: `APB_ARBITER_ROUND_ROBIN_EN`.
- **Defined**: round-robin arbitration as above.
- **Undefined**
  - Fixed priority: the lowest asserted index always wins.
  - `last` register is removed.
  - Higher-index masters may starve under continuous load.

## Structure
- Shared package `apb_arbiter_pkg` holds:
  - State encoding constants `ST_IDLE`=2'd0, `ST_SETUP`=2'd1, `ST_ACCESS`=2'd2, `ST_RESP`=2'd3.
  - `APB_DATA_W`=8.
- Sub-module `rr_priority_picker`: combinational, taking `req[MASTER_COUNT]` and `last` and producing `grant` one-hot plus `grant_idx`.
  - Under the fixed-priority build it reduces to a lowest-set-bit encoder.

## Test plan
- Single write: m0 request, addr 0x12, wdata 0xA5, pwrite 1 -> `PSEL` at +1, `PENABLE` at +2 with `PADDR`=0x12 and `PWDATA`=0xA5, `m_pready[0]` at +3.
- Single read: m1 request, addr 0x05, slave `PRDATA`=0x3C in ACCESS -> `m_prdata[1]`=0x3C while `m_pready[1]`=1; `m_prdata[0]`=0.
- Contention: m0 and m1 request continuously from reset -> grants m0, m1, m0, m1 at 4-cycle spacing. With the macro undefined, grants are m0, m0, m0.
- Late request: m1 requests during m0's ACCESS -> m1 is granted in the IDLE cycle after m0's RESP; `PSEL` for m1 rises exactly 2 cycles after `m_pready[0]`.
- Reset mid-transfer: `rst`=0 during ACCESS -> at the next edge all outputs are 0 and state is IDLE. After release, m0 is granted first.
- Dropped request: m0 deasserts `m_psel` during SETUP -> ACCESS still occurs and `m_pready[0]` still pulses once; the arbiter returns to IDLE.
